sw_input_port: RTL and testbench

//  Input-side peripheral feeding the CPU "in" operand. It is the counterpart of the led/hex output path.

---
 rtl/sw_input_port_pkg.sv | 18 +
 rtl/sw_debounce.sv | 65 ++++++
 rtl/sw_input_port.sv | 92 +++++++++
 tb/tb_sw_input_port.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sw_input_port_pkg.sv
// sw_input_port_pkg
//   Shared defaults for the switch input port and the operation
//   encoding used by its holding register.
package sw_input_port_pkg;

    localparam int unsigned DATA_WIDTH_DEF      = 16;
    localparam int unsigned SW_WIDTH_DEF        = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

    // What the holding register does on a given edge.
    typedef enum logic [1:0] {
        HOLD_KEEP,     // nothing changes
        HOLD_LOAD,     // capture switches, register becomes/stays full
        HOLD_CONSUME,  // CPU took the value, register empties
        HOLD_DROP      // press arrived while full and unacknowledged
    } hold_op_e;

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce
//   Two-flop synchroniser, stability counter and press pulse for one
//   raw push-button.
// Ports
//   clk      in  block clock
//   rst      in  synchronous reset, active-high
//   btn_i    in  raw asynchronous button level, active-high
//   press_o  out one-cycle pulse, valid on the edge where a debounced
//                release->press transition is accepted
module sw_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic [1:0]    vld_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          armed_q, armed_d;
    logic          accept;

    always_comb begin
        cnt_d   = '0;
        db_d    = db_q;
        accept  = (s2_q != db_q) && (cnt_q == CNT_LAST);
        if (s2_q != db_q) begin
            if (accept) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // Arm only once a genuinely synchronised low level is seen; vld_q
        // marks when the synchroniser no longer holds reset values. This
        // keeps a button held through reset from producing a capture.
        armed_d = armed_q | (vld_q[1] & ~s2_q);
        press_o = accept & s2_q & armed_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            vld_q   <= '0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            vld_q   <= {vld_q[0], 1'b1};
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/sw_input_port.sv
// sw_input_port
//   Input-side peripheral for the CPU "in" operand. Synchronises the
//   switches, debounces the load button, and on each press latches the
//   switches into a one-entry holding register offered to the CPU with a
//   valid/ack handshake. A press that finds the register full and not
//   being acknowledged is dropped and flagged as a sticky overrun.
// Ports
//   clk       in  block clock
//   rst       in  synchronous reset, active-high
//   sw        in  raw asynchronous switch levels
//   btn       in  raw asynchronous load button, active-high
//   in_ack    in  single-cycle pulse: CPU consumes the held value
//   in_valid  out holding register full
//   in_data   out zero-extended held switch value, stable while valid
//   overrun   out sticky dropped-press flag, cleared only by rst
module sw_input_port
    import sw_input_port_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int unsigned SW_WIDTH        = SW_WIDTH_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SW_WIDTH-1:0]   sw,
    input  logic                  btn,
    input  logic                  in_ack,
    output logic                  in_valid,
    output logic [DATA_WIDTH-1:0] in_data,
    output logic                  overrun
);

    logic [SW_WIDTH-1:0]   sw1_q, sw2_q;
    logic                  press;
    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ovr_q, ovr_d;
    hold_op_e              op;

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn),
        .press_o(press)
    );

    always_comb begin
        op = HOLD_KEEP;
        if (press) begin
            // An ack on the press edge frees the slot, so the new value loads.
            op = (full_q && !in_ack) ? HOLD_DROP : HOLD_LOAD;
        end else if (full_q && in_ack) begin
            op = HOLD_CONSUME;
        end

        full_d = full_q;
        data_d = data_q;
        ovr_d  = ovr_q;
        case (op)
            HOLD_LOAD: begin
                data_d = DATA_WIDTH'(sw2_q);
                full_d = 1'b1;
            end
            HOLD_CONSUME: full_d = 1'b0;
            HOLD_DROP:    ovr_d  = 1'b1;
            HOLD_KEEP:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw1_q  <= '0;
            sw2_q  <= '0;
            full_q <= 1'b0;
            data_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            sw1_q  <= sw;
            sw2_q  <= sw1_q;
            full_q <= full_d;
            data_q <= data_d;
            ovr_q  <= ovr_d;
        end
    end

    assign in_valid = full_q;
    assign in_data  = data_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_sw_input_port.sv
// tb_sw_input_port
//   Directed bench for sw_input_port with a history-based reference model.
module tb_sw_input_port;

    localparam int unsigned DW = 16;
    localparam int unsigned SW = 4;
    localparam int unsigned DC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] sw;
    logic          btn;
    logic          in_ack;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          overrun;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    sw_input_port #(
        .DATA_WIDTH     (DW),
        .SW_WIDTH       (SW),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .btn     (btn),
        .in_ack  (in_ack),
        .in_valid(in_valid),
        .in_data (in_data),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // Reference model: raw samples taken since reset are kept as history;
    // the synchronised value at edge n is the raw sample from edge n-2
    // (zero before that). A button change is accepted when the last DC
    // synchronised samples all differ from the debounced level.
    bit            bq[$];
    logic [SW-1:0] swq[$];
    bit            dq[$];
    bit            m_db, m_armed, m_valid, m_ovr;
    logic [DW-1:0] m_data;
    bit            bs, genuine, accept, press, all_diff;
    logic [SW-1:0] ss;
    int            n;

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            bq.delete();
            swq.delete();
            dq.delete();
            m_db    = 1'b0;
            m_armed = 1'b0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_data  = '0;
        end else begin
            n       = bq.size();
            genuine = (n >= 2);
            bs      = genuine ? bq[n-2] : 1'b0;
            ss      = genuine ? swq[n-2] : '0;
            dq.push_back(bs);
            accept = 1'b0;
            if (dq.size() >= DC) begin
                all_diff = 1'b1;
                for (int k = 0; k < DC; k++)
                    if (dq[dq.size()-1-k] == m_db) all_diff = 1'b0;
                accept = all_diff;
            end
            press = 1'b0;
            if (accept) begin
                m_db  = bs;
                press = bs && m_armed;
            end
            if (genuine && !bs) m_armed = 1'b1;
            if (press) begin
                if (m_valid && !in_ack) m_ovr = 1'b1;
                else begin
                    m_data  = DW'(ss);
                    m_valid = 1'b1;
                end
            end else if (m_valid && in_ack) begin
                m_valid = 1'b0;
            end
            bq.push_back(btn);
            swq.push_back(sw);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_in_valid", 32'(in_valid), 32'(m_valid));
            chk("model_in_data",  32'(in_data),  32'(m_data));
            chk("model_overrun",  32'(overrun),  32'(m_ovr));
        end
    end

    task automatic cycles(input int c);
        repeat (c) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; btn = 1'b1; sw = 4'hF; in_ack = 1'b0;
        cycles(2);
        chk("rst_valid", 32'(in_valid), 32'd0);
        chk("rst_data",  32'(in_data),  32'h0);
        chk("rst_ovr",   32'(overrun),  32'd0);
        rst = 1'b0;
        cycles(12);
        chk("held_no_capture", 32'(in_valid), 32'd0);
        chk("held_no_data",    32'(in_data),  32'h0);

        btn = 1'b0; sw = 4'hA;
        cycles(10);
        btn = 1'b1;
        cycles(5);
        chk("latency_edge4", 32'(in_valid), 32'd0);
        cycles(1);
        chk("latency_edge5_valid", 32'(in_valid), 32'd1);
        chk("latency_edge5_data",  32'(in_data),  32'h000A);
        cycles(3);
        chk("held_valid", 32'(in_valid), 32'd1);

        in_ack = 1'b1; cycles(1); in_ack = 1'b0;
        chk("ack_clear_valid", 32'(in_valid), 32'd0);
        chk("ack_keep_data",   32'(in_data),  32'h000A);
        cycles(2);
        in_ack = 1'b1; cycles(1); in_ack = 1'b0;
        chk("ack_empty_valid", 32'(in_valid), 32'd0);
        chk("ack_empty_ovr",   32'(overrun),  32'd0);
        btn = 1'b0;
        cycles(10);

        repeat (5) begin
            btn = 1'b1; cycles(3);
            btn = 1'b0; cycles(3);
            chk("glitch_ignored", 32'(in_valid), 32'd0);
        end
        cycles(6);

        sw = 4'h3; cycles(3);
        btn = 1'b1; cycles(8);
        chk("ovr_first_valid", 32'(in_valid), 32'd1);
        chk("ovr_first_data",  32'(in_data),  32'h0003);
        btn = 1'b0; cycles(8);
        sw = 4'h5; cycles(3);
        btn = 1'b1; cycles(8);
        chk("ovr_data_kept", 32'(in_data),  32'h0003);
        chk("ovr_set",       32'(overrun),  32'd1);
        chk("ovr_valid",     32'(in_valid), 32'd1);
        btn = 1'b0; cycles(8);
        in_ack = 1'b1; cycles(1); in_ack = 1'b0;
        chk("ovr_ack_valid",  32'(in_valid), 32'd0);
        chk("ovr_after_ack",  32'(overrun),  32'd1);
        cycles(3);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        rst = 1'b1; cycles(2); rst = 1'b0;
        chk("ovr_rst_clear", 32'(overrun),  32'd0);
        chk("rst2_valid",    32'(in_valid), 32'd0);
        chk("rst2_data",     32'(in_data),  32'h0);
        cycles(6);

        sw = 4'h3; cycles(3);
        btn = 1'b1; cycles(8);
        chk("swap_first_data", 32'(in_data), 32'h0003);
        btn = 1'b0; cycles(8);
        sw = 4'h6; cycles(3);
        btn = 1'b1; cycles(5);
        in_ack = 1'b1; cycles(1); in_ack = 1'b0;
        chk("swap_valid", 32'(in_valid), 32'd1);
        chk("swap_data",  32'(in_data),  32'h0006);
        chk("swap_ovr",   32'(overrun),  32'd0);
        cycles(2);
        chk("swap_valid_hold", 32'(in_valid), 32'd1);
        btn = 1'b0; cycles(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
